// File: rtl/divider_restoring_if.sv
// divider_restoring_if: operand/result handshake bundle; DIVIDER_DBZ_FLAG_EN adds the dbz flag.
interface divider_restoring_if #(parameter int DATA_W = 32);
  logic in_valid;
  logic in_ready;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic out_valid;
  logic out_ready;
  logic [DATA_W-1:0] Q;
  logic [DATA_W-1:0] R;
`ifdef DIVIDER_DBZ_FLAG_EN
  logic dbz;
  modport slave (input in_valid, A, B, out_ready, output in_ready, out_valid, Q, R, dbz);
  modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, Q, R, dbz);
`else
  modport slave (input in_valid, A, B, out_ready, output in_ready, out_valid, Q, R);
  modport master (output in_valid, A, B, out_ready, input in_ready, out_valid, Q, R);
`endif
endinterface

// File: rtl/divider_restoring.sv
// divider_restoring: signed restoring divider, one quotient bit per cycle; DIVIDER_DBZ_FLAG_EN enables the dbz flag/fast path.
module divider_restoring #(
  parameter int DATA_W = 32
) (
  input logic clk,
  input logic rst_n,
  divider_restoring_if.slave io
);
  localparam int CW = $clog2(DATA_W);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d, q_q, q_d, r_q, r_d;
  logic [DATA_W:0] div_q, div_d, shifted;
  logic [DATA_W+1:0] trial;
  logic [DATA_W-1:0] a_mag, b_mag, rem_n, quo_n;
  logic sq_q, sq_d, sr_q, sr_d;
`ifdef DIVIDER_DBZ_FLAG_EN
  logic dbz_q, dbz_d;
`endif
  always_comb begin
    a_mag = io.A[DATA_W-1] ? -io.A : io.A;
    b_mag = io.B[DATA_W-1] ? -io.B : io.B;
    shifted = {rem_q, quo_q[DATA_W-1]};
    trial = {1'b0, shifted} - {1'b0, div_q};
    rem_n = trial[DATA_W+1] ? DATA_W'(shifted) : DATA_W'(trial);
    quo_n = {quo_q[DATA_W-2:0], ~trial[DATA_W+1]};
    state_d = state_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    div_d = div_q;
    q_d = q_q;
    r_d = r_q;
    sq_d = sq_q;
    sr_d = sr_q;
`ifdef DIVIDER_DBZ_FLAG_EN
    dbz_d = dbz_q;
`endif
    case (state_q)
      IDLE: if (io.in_valid) begin
        state_d = CALC;
        cnt_d = '0;
        rem_d = '0;
        quo_d = a_mag;
        div_d = {1'b0, b_mag};
        // a zero divisor keeps the quotient at all ones irrespective of the dividend sign
        sq_d = (io.A[DATA_W-1] ^ io.B[DATA_W-1]) && |io.B;
        sr_d = io.A[DATA_W-1];
`ifdef DIVIDER_DBZ_FLAG_EN
        dbz_d = ~|io.B;
        if (~|io.B) begin
          state_d = DONE;
          q_d = '1;
          r_d = io.A;
        end
`endif
      end
      CALC: begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DATA_W - 1)) begin
          state_d = DONE;
          q_d = sq_q ? -quo_n : quo_n;
          r_d = sr_q ? -rem_n : rem_n;
        end
      end
      DONE: state_d = io.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      div_q <= '0;
      q_q <= '0;
      r_q <= '0;
      sq_q <= 1'b0;
      sr_q <= 1'b0;
`ifdef DIVIDER_DBZ_FLAG_EN
      dbz_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      div_q <= div_d;
      q_q <= q_d;
      r_q <= r_d;
      sq_q <= sq_d;
      sr_q <= sr_d;
`ifdef DIVIDER_DBZ_FLAG_EN
      dbz_q <= dbz_d;
`endif
    end
  end
  assign io.in_ready = state_q == IDLE;
  assign io.out_valid = state_q == DONE;
  assign io.Q = q_q;
  assign io.R = r_q;
`ifdef DIVIDER_DBZ_FLAG_EN
  assign io.dbz = dbz_q;
`endif
endmodule

// File: tb/tb_divider_restoring.sv
// tb_divider_restoring: directed/scoreboard bench for divider_restoring at DATA_W=32.
module tb_divider_restoring;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  divider_restoring_if #(.DATA_W(32)) io ();
  divider_restoring #(.DATA_W(32)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  typedef struct packed {logic [31:0] q; logic [31:0] r; logic dbz;} exp_t;
`ifdef DIVIDER_DBZ_FLAG_EN
  localparam logic DBZ_EN = 1'b1;
`else
  localparam logic DBZ_EN = 1'b0;
`endif
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic signed [31:0] a, input logic signed [31:0] b);
    if (b == 0) return '{q: 32'hFFFFFFFF, r: a, dbz: DBZ_EN};
    if (a == 32'sh80000000 && b == -32'sd1) return '{q: a, r: 32'h0, dbz: 1'b0};
    return '{q: a / b, r: a % b, dbz: 1'b0};
  endfunction
  function automatic int lat_of(input logic [31:0] b);
    return (DBZ_EN && b == 0) ? 1 : 33;
  endfunction
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input exp_t e);
    @(negedge clk);
    io.A = a;
    io.B = b;
    io.in_valid = 1'b1;
    chk("in_ready_before_accept", {31'b0, io.in_ready}, 1);
    sb.push_back(e);
  endtask
  task automatic collect(input string tag, input int exp_lat, input logic rel);
    int n;
    exp_t e;
    @(posedge clk);
    n = 1;
    #1;
    io.in_valid = 1'b0;
    io.A = $urandom;
    io.B = $urandom;
    @(negedge clk);
    while (!io.out_valid && n < 100) begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end
    chk({tag, "_latency"}, n, exp_lat);
    chk({tag, "_sb_nonempty"}, {31'b0, sb.size() != 0}, 1);
    e = sb.size() != 0 ? sb.pop_front() : '0;
    chk({tag, "_Q"}, io.Q, e.q);
    chk({tag, "_R"}, io.R, e.r);
`ifdef DIVIDER_DBZ_FLAG_EN
    chk({tag, "_dbz"}, {31'b0, io.dbz}, {31'b0, e.dbz});
`endif
    if (rel) begin
      io.out_ready = 1'b1;
      @(posedge clk);
      #1 io.out_ready = 1'b0;
    end
  endtask
  initial begin
    exp_t h;
    logic [31:0] ra, rb;
    logic stayed_low;
    io.in_valid = 1'b0;
    io.out_ready = 1'b0;
    io.A = '0;
    io.B = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'b0, io.in_ready}, 1);
    chk("rst_out_valid", {31'b0, io.out_valid}, 0);
    chk("rst_Q", io.Q, 0);
    chk("rst_R", io.R, 0);
`ifdef DIVIDER_DBZ_FLAG_EN
    chk("rst_dbz", {31'b0, io.dbz}, 0);
`endif
    rst_n = 1'b1;
    launch(100, 7, '{q: 14, r: 2, dbz: 0});
    collect("p100_p7", 33, 1);
    launch(-100, 7, '{q: 32'hFFFFFFF2, r: 32'hFFFFFFFE, dbz: 0});
    collect("m100_p7", 33, 1);
    launch(100, -7, '{q: 32'hFFFFFFF2, r: 2, dbz: 0});
    collect("p100_m7", 33, 1);
    launch(-100, -7, '{q: 14, r: 32'hFFFFFFFE, dbz: 0});
    collect("m100_m7", 33, 1);
    launch(32'h80000000, 32'hFFFFFFFF, '{q: 32'h80000000, r: 0, dbz: 0});
    collect("min_by_m1", 33, 1);
    launch(5, 0, '{q: 32'hFFFFFFFF, r: 5, dbz: DBZ_EN});
    collect("p5_by_0", lat_of(0), 1);
    launch(-5, 0, '{q: 32'hFFFFFFFF, r: 32'hFFFFFFFB, dbz: DBZ_EN});
    collect("m5_by_0", lat_of(0), 1);
    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = {$urandom_range(0, 1) == 1 ? 16'hFFFF : 16'h0000, 16'($urandom_range(1, 30000))};
      launch(ra, rb, model(ra, rb));
      collect("rand", 33, 1);
    end
    h = model(1000, -33);
    launch(1000, -33, h);
    collect("hold", 33, 0);
    io.A = 7;
    io.B = 2;
    io.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_out_valid", {31'b0, io.out_valid}, 1);
      chk("hold_in_ready", {31'b0, io.in_ready}, 0);
      chk("hold_Q", io.Q, h.q);
      chk("hold_R", io.R, h.r);
    end
    io.out_ready = 1'b1;
    @(posedge clk);
    #1 io.out_ready = 1'b0;
    @(negedge clk);
    chk("after_done_in_ready", {31'b0, io.in_ready}, 1);
    chk("after_done_out_valid", {31'b0, io.out_valid}, 0);
    sb.push_back(model(7, 2));
    collect("p7_p2_after_hold", 33, 1);
    launch(123456, 77, model(123456, 77));
    void'(sb.pop_back());
    @(posedge clk);
    #1 io.in_valid = 1'b0;
    repeat (16) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", {31'b0, io.in_ready}, 1);
    chk("abort_out_valid", {31'b0, io.out_valid}, 0);
    chk("abort_Q", io.Q, 0);
    chk("abort_R", io.R, 0);
    stayed_low = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (io.out_valid !== 1'b0) stayed_low = 1'b0;
    end
    chk("abort_no_out_valid", {31'b0, stayed_low}, 1);
    launch(9, 3, '{q: 3, r: 0, dbz: 0});
    collect("p9_p3", 33, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
